ikaopll_wrseq: RTL
==================

# ikaopll_wrseq

Host-side register write sequencer that sits directly upstream of the chip bus port (`i_CS_n`/`i_WR_n`/`i_A0`/`i_D`). It accepts (address, data) register writes through a valid/ready handshake and buffers them in a small FIFO. It replays each write as an address cycle followed by a data cycle. The required post-write wait times are enforced by counting phiM clock enables, so a host can stream writes without software delay loops.

## Interface
Parameters:
- `FIFO_DEPTH_LOG2`, 2, FIFO holds 2^N writes (N = 1..4).
- `WR_PULSE`, 2, phiM enables `o_WR_n` is held low per bus cycle (≥1).
- `ADDR_WAIT`, 12, phiM enables from address-cycle `o_WR_n` rise to data-cycle setup (≥2).
- `DATA_WAIT`, 84, phiM enables from data-cycle `o_WR_n` rise to next address setup (≥2).

Ports:
- `i_EMUCLK` in 1: emulator master clock, same as XIN; the only clock.
- `i_RST` in 1: asynchronous, active-high reset.
- `i_phiM_PCEN_n` in 1: phiM positive-edge clock enable, negative logic; all timed states advance only when it is low.
- `i_REG_ADDR` in 8: register address.
- `i_REG_DATA` in 8: register data.
- `i_REG_VALID` in 1: write request.
- `o_REG_READY` out 1: FIFO can accept; a push occurs when VALID & READY.
- `o_LEVEL` out FIFO_DEPTH_LOG2+1: FIFO occupancy.
- `o_BUSY` out 1: sequencer not IDLE or FIFO non-empty.
- `o_CS_n`, `o_WR_n` out 1: chip select and write strobe to the chip.
- `o_A0` out 1: 0 = address cycle, 1 = data cycle.
- `o_D` out 8: bus data to the chip.

## Operation
- FIFO entry is {addr, data}, 16 bits.
- `o_REG_READY` = !full & !i_RST. Readiness is based on the registered full flag: when the FIFO is full, a same-cycle pop does not allow a push.
- States: IDLE, A_SETUP, A_STROBE, A_HOLD, A_WAIT, D_SETUP, D_STROBE, D_HOLD, D_WAIT.
- **IDLE:** on any clock with the FIFO non-empty, pop the entry into a holding register and go to A_SETUP. The pop does not wait for an enable.
- **A_SETUP:** `o_CS_n`=0, `o_A0`=0, `o_D`=addr, `o_WR_n`=1. Lasts 1 enable.
- **A_STROBE:** as A_SETUP, but `o_WR_n`=0. Lasts WR_PULSE enables.
- **A_HOLD:** as A_SETUP. Lasts 1 enable.
- **A_WAIT:** `o_CS_n`=1, `o_WR_n`=1, `o_A0` and `o_D` hold their values. Lasts ADDR_WAIT-1 enables.
- **D_SETUP, D_STROBE, D_HOLD, D_WAIT:** same pattern with `o_A0`=1 and `o_D`=data. D_WAIT lasts DATA_WAIT-1 enables, then the FSM returns to IDLE.
- Wait counter: a single down-counter sized for max(ADDR_WAIT, DATA_WAIT, WR_PULSE). It is loaded on each state entry and decremented only on enable cycles. The state exits on the enable cycle where the count is 1.
- Push and pop in the same cycle: level unchanged, both accepted (non-full case only).
- Pointer wrap: read and write pointers are modulo 2^N. Full and empty are distinguished by the extra level bit.
- Reset asserted mid-operation:
  - bus outputs return to idle immediately (async);
  - FIFO is emptied and the held entry is discarded;
  - no partial cycle is resumed after release.

## Timing
- Reset values: `o_CS_n`=1, `o_WR_n`=1, `o_A0`=0, `o_D`=0, `o_LEVEL`=0, `o_BUSY`=0, `o_REG_READY`=0 while reset is asserted and 1 after release.
- All outputs are registered (no combinational path from `i_REG_*` to the bus pins). The exception is `o_REG_READY`, which is decoded from the registered full flag.
- Latency from push into an empty idle FIFO:
  - pop on the next clock;
  - `o_CS_n` falls on the clock after the pop;
  - A_SETUP then lasts until its first enable.
- Per-write bus time, in phiM enables: (1 + WR_PULSE + ADDR_WAIT) + (1 + WR_PULSE + DATA_WAIT). With default parameters this is 15 + 87 = 102 enables.
- `o_A0` and `o_D` are stable from SETUP through HOLD, which guarantees 1 enable of setup and 1 enable of hold around `o_WR_n` low.
- If `i_phiM_PCEN_n` is stuck high, the FSM freezes in its current state with outputs constant.

## Structure
- Package `ikaopll_wrseq_pkg` holds:
  - the state enum;
  - the FIFO entry width constant (16);
  - a counter-width function computing clog2 of the largest wait.
- Sub-module `ikaopll_wrseq_fifo` implements the synchronous FIFO (depth 2^N, async active-high reset, push/pop, full/empty/level). The top module holds the FSM, wait counter and bus output registers.

## Test plan
- **Single write, defaults, enable every 4th clock:** push (0x10, 0x55).
  - Required: address cycle with `o_A0`=0 and `o_D`=0x10, WR_n low for exactly 2 enables, then 12 enables to D_SETUP.
  - Required: data cycle with `o_A0`=1 and `o_D`=0x55, then 84 enables before IDLE.
  - Required: `o_BUSY` drops after the last enable.
- **Back-to-back pushes, depth 4:** push 6 writes continuously.
  - Required: 5 writes are accepted (1 popped immediately plus 4 buffered); `o_REG_READY` then drops and `o_LEVEL` reads 4.
  - Required: all 6 writes appear on the bus in order, 102 enables apart.
- **Enable gaps:** hold `i_phiM_PCEN_n`=1 for 50 clocks during A_STROBE → `o_WR_n` stays low and the state does not advance; the strobe resumes and completes with an exact 2-enable count.
- **Reset during D_STROBE with 3 entries queued:** assert `i_RST` → `o_CS_n`, `o_WR_n` = 1 and `o_LEVEL`=0 immediately; after release, no bus activity occurs without new pushes.
- **Parameter sweep WR_PULSE=1, ADDR_WAIT=2, DATA_WAIT=2:** one write → total bus time of 8 enables, with the setup/hold ordering intact.
- **Push while full with a simultaneous pop:** VALID is held high → the push is not accepted that cycle and is accepted the following cycle; no entry is lost or duplicated.

Source files
------------

// File: rtl/ikaopll_wrseq_pkg.sv
// Shared state encoding, FIFO entry layout and wait-counter sizing for the
// OPLL register write sequencer.
package ikaopll_wrseq_pkg;

   localparam int ENTRY_W = 16;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_A_SETUP,
      ST_A_STROBE,
      ST_A_HOLD,
      ST_A_WAIT,
      ST_D_SETUP,
      ST_D_STROBE,
      ST_D_HOLD,
      ST_D_WAIT
   } wrseq_state_e;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } wr_entry_t;

   // Wide enough to hold the largest value ever loaded into the wait counter.
   function automatic int cnt_width(input int wr_pulse, input int addr_wait, input int data_wait);
      int m;
      m = wr_pulse;
      if (addr_wait > m) m = addr_wait;
      if (data_wait > m) m = data_wait;
      return (m < 2) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/ikaopll_wrseq_fifo.sv
// Synchronous 2^N-entry FIFO; pop data is the head entry, readable before the pop.
// Latency: pushed entry visible one clock later; backpressure: push ignored while full.
module ikaopll_wrseq_fifo #(
   parameter int DEPTH_LOG2 = 2,
   parameter int W          = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [W-1:0]          push_dat,
   input  logic                  pop,
   output logic [W-1:0]          pop_dat,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   level
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [W-1:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0]   wr_ptr;
   logic [DEPTH_LOG2-1:0]   rd_ptr;
   logic                    do_push;
   logic                    do_pop;

   // Level never exceeds DEPTH, so its MSB alone marks full.
   assign full    = level[DEPTH_LOG2];
   assign empty   = (level == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign pop_dat = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         level <= level + {{DEPTH_LOG2{1'b0}}, do_push} - {{DEPTH_LOG2{1'b0}}, do_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end

endmodule

// File: rtl/ikaopll_wrseq.sv
// Replays buffered (addr, data) writes onto the OPLL bus as address then data cycles.
// Latency: pop one clock after push, CS_n one clock after pop; backpressure: READY low while FIFO full.
module ikaopll_wrseq
   import ikaopll_wrseq_pkg::*;
#(
   parameter int FIFO_DEPTH_LOG2 = 2,
   parameter int WR_PULSE        = 2,
   parameter int ADDR_WAIT       = 12,
   parameter int DATA_WAIT       = 84
) (
   input  logic                     i_EMUCLK,
   input  logic                     i_RST,
   input  logic                     i_phiM_PCEN_n,
   input  logic [7:0]               i_REG_ADDR,
   input  logic [7:0]               i_REG_DATA,
   input  logic                     i_REG_VALID,
   output logic                     o_REG_READY,
   output logic [FIFO_DEPTH_LOG2:0] o_LEVEL,
   output logic                     o_BUSY,
   output logic                     o_CS_n,
   output logic                     o_WR_n,
   output logic                     o_A0,
   output logic [7:0]               o_D
);

   localparam int CW = cnt_width(WR_PULSE, ADDR_WAIT, DATA_WAIT);
   localparam logic [CW-1:0] LD_ONE   = CW'(1);
   localparam logic [CW-1:0] LD_PULSE = CW'(WR_PULSE);
   localparam logic [CW-1:0] LD_AWAIT = CW'(ADDR_WAIT - 1);
   localparam logic [CW-1:0] LD_DWAIT = CW'(DATA_WAIT - 1);

   wrseq_state_e  state;
   logic [CW-1:0] cnt;
   wr_entry_t     held;
   wr_entry_t     fifo_dat;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          en;
   logic          cnt_done;

   assign o_REG_READY = ~full & ~i_RST;
   assign push        = i_REG_VALID & o_REG_READY;
   assign pop         = (state == ST_IDLE) & ~empty;
   assign en          = ~i_phiM_PCEN_n;
   assign cnt_done    = en & (cnt == LD_ONE);

   ikaopll_wrseq_fifo #(
      .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
      .W          (ENTRY_W)
   ) u_fifo (
      .clk      (i_EMUCLK),
      .rst      (i_RST),
      .push     (push),
      .push_dat ({i_REG_ADDR, i_REG_DATA}),
      .pop      (pop),
      .pop_dat  (fifo_dat),
      .full     (full),
      .empty    (empty),
      .level    (o_LEVEL)
   );

   always_ff @(posedge i_EMUCLK or posedge i_RST) begin
      if (i_RST) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         held   <= '0;
         o_CS_n <= 1'b1;
         o_WR_n <= 1'b1;
         o_A0   <= 1'b0;
         o_D    <= '0;
         o_BUSY <= 1'b0;
      end else begin
         if (en && state != ST_IDLE) cnt <= cnt - 1'b1;
         case (state)
            ST_IDLE:     if (!empty)   begin held <= fifo_dat; state <= ST_A_SETUP; cnt <= LD_ONE; end
            ST_A_SETUP:  if (cnt_done) begin state <= ST_A_STROBE; cnt <= LD_PULSE; end
            ST_A_STROBE: if (cnt_done) begin state <= ST_A_HOLD;   cnt <= LD_ONE;   end
            ST_A_HOLD:   if (cnt_done) begin state <= ST_A_WAIT;   cnt <= LD_AWAIT; end
            ST_A_WAIT:   if (cnt_done) begin state <= ST_D_SETUP;  cnt <= LD_ONE;   end
            ST_D_SETUP:  if (cnt_done) begin state <= ST_D_STROBE; cnt <= LD_PULSE; end
            ST_D_STROBE: if (cnt_done) begin state <= ST_D_HOLD;   cnt <= LD_ONE;   end
            ST_D_HOLD:   if (cnt_done) begin state <= ST_D_WAIT;   cnt <= LD_DWAIT; end
            ST_D_WAIT:   if (cnt_done) state <= ST_IDLE;
            default:     state <= ST_IDLE;
         endcase

         // Bus pins are registered from the current state, so they trail it by one clock.
         case (state)
            ST_A_SETUP, ST_A_HOLD: begin o_CS_n <= 1'b0; o_WR_n <= 1'b1; o_A0 <= 1'b0; o_D <= held.addr; end
            ST_A_STROBE:           begin o_CS_n <= 1'b0; o_WR_n <= 1'b0; o_A0 <= 1'b0; o_D <= held.addr; end
            ST_D_SETUP, ST_D_HOLD: begin o_CS_n <= 1'b0; o_WR_n <= 1'b1; o_A0 <= 1'b1; o_D <= held.data; end
            ST_D_STROBE:           begin o_CS_n <= 1'b0; o_WR_n <= 1'b0; o_A0 <= 1'b1; o_D <= held.data; end
            default:               begin o_CS_n <= 1'b1; o_WR_n <= 1'b1; end
         endcase

         o_BUSY <= !empty || push || !(state == ST_IDLE || (state == ST_D_WAIT && cnt_done));
      end
   end

endmodule
